// File: rtl/clk_div_multi.sv
// Multi-channel clock-enable / tick generator.
// Each channel counts live cycles up to its active divisor, then emits a
// one-cycle tick and either toggles clk_out (free-run) or stops and raises a
// sticky done flag (one-shot). Divisor writes land in a shadow register and
// reach the active divisor only at a terminal count, a start, or while the
// channel is idle, so a running output never sees a shortened period.
module clk_div_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 26,
  parameter int DEFAULT_DIV = 500000,
  parameter int SEL_W       = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              div_we,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_wdata,
  input  logic [NUM_CH-1:0] mode,
  input  logic [NUM_CH-1:0] start,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] done
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_a;    // divisor in use
    logic [CNT_W-1:0] div_s;    // divisor waiting for the next reload point
    logic             running;  // one-shot armed
    logic             clk_out;
    logic             tick;
    logic             done;
  } ch_t;

  ch_t ch_q [NUM_CH];
  ch_t ch_d [NUM_CH];

  logic [NUM_CH-1:0]      wr_hit;   // this channel is addressed by a write
  logic [NUM_CH-1:0]      live;     // this channel counts this cycle
  logic [NUM_CH-1:0]      at_term;  // counter reached (or passed) the divisor
  logic [NUM_CH-1:0]      restart;  // one-shot start strobe
  logic [CNT_W-1:0]       reload [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    // A div_sel beyond the last channel matches no channel, so it is dropped.
    assign wr_hit[g]  = div_we && (div_sel == SEL_W'(g));
    assign live[g]    = enable && (!mode[g] || ch_q[g].running);
    // ">=" rather than "==": an idle load may leave the counter above div_a.
    assign at_term[g] = ch_q[g].cnt >= ch_q[g].div_a;
    assign restart[g] = mode[g] && start[g];
    // A write coinciding with a reload point takes effect at once.
    assign reload[g]  = wr_hit[g] ? div_wdata : ch_q[g].div_s;

    assign clk_out[g] = ch_q[g].clk_out;
    assign tick[g]    = ch_q[g].tick;
    assign done[g]    = ch_q[g].done;
  end

  // Next-state logic for every channel.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      // NOTE: every field gets a default before any branch so no path
      // leaves a value unassigned and no latch is inferred.
      ch_d[i]      = ch_q[i];
      ch_d[i].tick = 1'b0;

      if (wr_hit[i]) ch_d[i].div_s = div_wdata;

      if (restart[i]) begin
        // Start wins over a coincident terminal count: no tick this cycle.
        ch_d[i].cnt     = '0;
        ch_d[i].running = 1'b1;
        ch_d[i].done    = 1'b0;
        ch_d[i].div_a   = reload[i];
      end else if (!live[i]) begin
        if (wr_hit[i]) ch_d[i].div_a = div_wdata;
      end else if (at_term[i]) begin
        ch_d[i].cnt   = '0;
        ch_d[i].tick  = 1'b1;
        ch_d[i].div_a = reload[i];
        if (mode[i]) begin
          ch_d[i].running = 1'b0;
          ch_d[i].done    = 1'b1;
        end else begin
          ch_d[i].clk_out = ~ch_q[i].clk_out;
        end
      end else begin
        ch_d[i].cnt = ch_q[i].cnt + CNT_W'(1);
      end

      // Free-run mode disarms the one-shot so a later switch back waits for start.
      if (!mode[i]) ch_d[i].running = 1'b0;
    end
  end

  // Channel state registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        // NOTE: the divisor registers are reset too; a channel must come out
        // of reset with a known period, and pending shadow writes are dropped.
        ch_q[i].cnt     <= '0;
        ch_q[i].div_a   <= DIV_RST;
        ch_q[i].div_s   <= DIV_RST;
        ch_q[i].running <= 1'b0;
        ch_q[i].clk_out <= 1'b0;
        ch_q[i].tick    <= 1'b0;
        ch_q[i].done    <= 1'b0;
      end
    end else begin
      // NOTE: non-blocking assignment so every register updates from the
      // values present before the edge.
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= ch_d[i];
    end
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: directed scenarios with hand-derived
// expectations, plus randomized traffic compared every cycle against a
// behavioural model of the channel rules.
module tb_clk_div_multi;

  localparam int NUM_CH      = 2;
  localparam int CNT_W       = 8;
  localparam int DEFAULT_DIV = 3;
  localparam int SEL_W       = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              div_we;
  logic [SEL_W-1:0]  div_sel;
  logic [CNT_W-1:0]  div_wdata;
  logic [NUM_CH-1:0] mode;
  logic [NUM_CH-1:0] start;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] done;

  int n_checks = 0;
  int n_fail   = 0;
  bit sb_on    = 1'b0;
  logic [NUM_CH-1:0] exp_clk;

  clk_div_multi #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .div_we(div_we),
    .div_sel(div_sel), .div_wdata(div_wdata), .mode(mode), .start(start),
    .clk_out(clk_out), .tick(tick), .done(done)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  int m_cnt  [NUM_CH];
  int m_diva [NUM_CH];
  int m_divs [NUM_CH];
  bit m_run  [NUM_CH];
  bit m_clk  [NUM_CH];
  bit m_tick [NUM_CH];
  bit m_done [NUM_CH];

  function automatic bit is_live(int ch);
    return enable && (!mode[ch] || m_run[ch]);
  endfunction

  function automatic bit is_wr(int ch);
    return div_we && (int'(div_sel) == ch);
  endfunction

  function automatic int next_div(int ch);
    return is_wr(ch) ? int'(div_wdata) : m_divs[ch];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_cnt[i] <= 0; m_diva[i] <= DEFAULT_DIV; m_divs[i] <= DEFAULT_DIV;
        m_run[i] <= 0; m_clk[i] <= 0; m_tick[i] <= 0; m_done[i] <= 0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_tick[i] <= 0;
        if (is_wr(i)) m_divs[i] <= int'(div_wdata);
        if (mode[i] && start[i]) begin
          m_cnt[i] <= 0; m_run[i] <= 1; m_done[i] <= 0; m_diva[i] <= next_div(i);
        end else if (!is_live(i)) begin
          if (is_wr(i)) m_diva[i] <= int'(div_wdata);
        end else if (m_cnt[i] >= m_diva[i]) begin
          m_cnt[i] <= 0; m_tick[i] <= 1; m_diva[i] <= next_div(i);
          if (mode[i]) begin m_run[i] <= 0; m_done[i] <= 1; end
          else m_clk[i] <= !m_clk[i];
        end else begin
          m_cnt[i] <= m_cnt[i] + 1;
        end
        if (!mode[i]) m_run[i] <= 0;
      end
    end
  end

  // Every-cycle comparison of the DUT outputs against the model.
  always @(negedge clk) begin
    if (sb_on && !reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        n_checks++;
        if ({clk_out[i], tick[i], done[i]} !== {m_clk[i], m_tick[i], m_done[i]}) begin
          n_fail++;
          $display("FAIL model_ch%0d t=%0t: clk_out/tick/done got %b%b%b expected %b%b%b",
                   i, $time, clk_out[i], tick[i], done[i], m_clk[i], m_tick[i], m_done[i]);
        end
      end
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; div_we = 1'b0; div_sel = '0; div_wdata = '0;
    mode = '0; start = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({clk_out, tick, done} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_state: got clk_out=%b tick=%b done=%b expected all 0", clk_out, tick, done);
    end
    reset = 1'b0; enable = 1'b1; sb_on = 1'b1;
  endtask

  task automatic test_free_run();
    logic [NUM_CH-1:0] exp_tick;
    exp_clk = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_tick = (k % 4 == 0) ? 2'b11 : 2'b00;
      exp_clk ^= exp_tick;
      n_checks++;
      if (tick !== exp_tick || clk_out !== exp_clk) begin
        n_fail++;
        $display("FAIL free_run cycle %0d: got tick=%b clk_out=%b expected tick=%b clk_out=%b",
                 k, tick, clk_out, exp_tick, exp_clk);
      end
    end
  endtask

  task automatic test_div_write();
    logic [NUM_CH-1:0] exp_tick;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_tick[0] = (k == 4) || (k > 4 && k % 2 == 0);
      exp_tick[1] = (k % 4 == 0);
      exp_clk ^= exp_tick;
      n_checks++;
      if (tick !== exp_tick || clk_out !== exp_clk) begin
        n_fail++;
        $display("FAIL div_write cycle %0d: got tick=%b clk_out=%b expected tick=%b clk_out=%b",
                 k, tick, clk_out, exp_tick, exp_clk);
      end
      if (k == 1) begin div_we = 1'b1; div_sel = 2'd0; div_wdata = 8'd1; end
      else div_we = 1'b0;
    end
  endtask

  task automatic test_one_shot();
    mode = 2'b10; div_we = 1'b1; div_sel = 2'd1; div_wdata = 8'd5;
    @(negedge clk);
    div_we = 1'b0;
    for (int rep = 0; rep < 2; rep++) begin
      start = 2'b10;
      @(negedge clk);
      start = 2'b00;
      n_checks++;
      if (done[1] !== 1'b0 || tick[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL one_shot_start%0d: got done=%b tick=%b expected 0 0", rep, done[1], tick[1]);
      end
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        n_checks++;
        if (tick[1] !== (k == 6) || done[1] !== (k >= 6) || clk_out[1] !== exp_clk[1]) begin
          n_fail++;
          $display("FAIL one_shot%0d cycle %0d: got tick=%b done=%b clk_out=%b expected %b %b %b",
                   rep, k, tick[1], done[1], clk_out[1], k == 6, k >= 6, exp_clk[1]);
        end
      end
    end
  endtask

  task automatic test_enable_freeze();
    logic [NUM_CH-1:0] held;
    div_we = 1'b1; div_sel = 2'd1; div_wdata = 8'd3;
    @(negedge clk);
    div_we = 1'b0; start = 2'b10;
    @(negedge clk);
    start = 2'b00;
    repeat (2) @(negedge clk);   // ch1 counter now 2
    enable = 1'b0;
    held = {m_clk[1], m_clk[0]};
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (tick !== 2'b00 || clk_out !== held || done[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL freeze cycle %0d: got tick=%b clk_out=%b done1=%b expected 00 %b 0",
                 k, tick, clk_out, done[1], held);
      end
    end
    enable = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (tick[1] !== (k == 2) || done[1] !== (k == 2)) begin
        n_fail++;
        $display("FAIL resume cycle %0d: got tick1=%b done1=%b expected %b %b",
                 k, tick[1], done[1], k == 2, k == 2);
      end
    end
  endtask

  task automatic test_start_on_terminal();
    start = 2'b10;
    @(negedge clk);
    start = 2'b00;
    repeat (3) @(negedge clk);   // ch1 counter now equals div_a = 3
    start = 2'b10;
    @(negedge clk);
    start = 2'b00;
    n_checks++;
    if (tick[1] !== 1'b0 || done[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL start_on_term: got tick1=%b done1=%b expected 0 0", tick[1], done[1]);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (tick[1] !== (k == 4) || done[1] !== (k == 4)) begin
        n_fail++;
        $display("FAIL after_restart cycle %0d: got tick1=%b done1=%b expected %b %b",
                 k, tick[1], done[1], k == 4, k == 4);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      found = m_clk[0] && m_done[1];
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL reset_mid_setup: clk_out0=1 with done1=1 not reached within 10 cycles");
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({clk_out, tick, done} !== 6'b0) begin
      n_fail++;
      $display("FAIL async_reset: got clk_out=%b tick=%b done=%b expected all 0", clk_out, tick, done);
    end
    @(negedge clk);
    reset = 1'b0; mode = 2'b00; enable = 1'b1;
    div_we = 1'b1; div_sel = 2'd3; div_wdata = 8'd1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      div_we = 1'b0;
      n_checks++;
      if (tick !== ((k % 4 == 0) ? 2'b11 : 2'b00)) begin
        n_fail++;
        $display("FAIL post_reset cycle %0d: got tick=%b expected %b",
                 k, tick, (k % 4 == 0) ? 2'b11 : 2'b00);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      enable    = ($urandom_range(0, 9) != 0);
      div_we    = ($urandom_range(0, 5) == 0);
      div_sel   = SEL_W'($urandom_range(0, 3));
      div_wdata = CNT_W'($urandom_range(0, 6));
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(0, 49) == 0) mode[i] = ~mode[i];
        start[i] = ($urandom_range(0, 11) == 0);
      end
      if ($urandom_range(0, 399) == 0) begin
        #2 reset = 1'b1;
        #2 reset = 1'b0;
      end
    end
    @(negedge clk);
    div_we = 1'b0; start = '0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_div_write();
    test_one_shot();
    test_enable_freeze();
    test_start_on_terminal();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
